// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA types, opcode constants, FSM states and encode helpers
// Contents: mnem_e (4-bit mnemonic), OP_* opcodes, DONE_WORD, instr_t,
//           state_e (loader FSM), is_legal(), encode().
package isa_pkg;

    typedef logic [8:0] instr_t;

    typedef enum logic [3:0] {
        MN_XOR   = 4'd0,
        MN_LW    = 4'd1,
        MN_SW    = 4'd2,
        MN_MOV   = 4'd3,
        MN_PUT   = 4'd4,
        MN_ADD   = 4'd5,
        MN_SUB   = 4'd6,
        MN_SL    = 4'd7,
        MN_SR    = 4'd8,
        MN_INC   = 4'd9,
        MN_DEC   = 4'd10,
        MN_AND   = 4'd11,
        MN_BNE   = 4'd12,
        MN_DONE  = 4'd13,
        MN_ILL14 = 4'd14,
        MN_ILL15 = 4'd15
    } mnem_e;

    localparam logic [4:0] OP_XOR  = 5'd0;
    localparam logic [4:0] OP_LW   = 5'd1;
    localparam logic [4:0] OP_SW   = 5'd2;
    localparam logic [4:0] OP_MOV  = 5'd3;
    localparam logic [4:0] OP_PUT  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SL   = 5'd7;
    localparam logic [4:0] OP_SR   = 5'd8;
    localparam logic [4:0] OP_INC  = 5'd9;
    localparam logic [4:0] OP_DEC  = 5'd10;
    localparam logic [4:0] OP_AND  = 5'd11;
    localparam logic [4:0] OP_DONE = 5'b01111;

    localparam instr_t DONE_WORD = 9'h0F0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_TERM,
        ST_COMPLETE
    } state_e;

    function automatic logic is_legal(input logic [3:0] mnem);
        return mnem <= 4'(MN_DONE);
    endfunction

    // ALU/memory ops reuse the mnemonic as the opcode; bne spends bit 8 as
    // its own format flag so the full 8-bit target fits.
    function automatic instr_t encode(input logic [3:0] mnem, input logic [7:0] operand);
        if (mnem == 4'(MN_BNE)) begin
            return {1'b1, operand};
        end else if (mnem == 4'(MN_DONE)) begin
            return {OP_DONE, operand[3:0]};
        end else begin
            return {1'b0, mnem, operand[3:0]};
        end
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - symbolic instruction stream and imem write port bundle
// Signals: in_valid/in_ready/in_mnem/in_operand (stream), imem_stall/imem_we/
//          imem_addr/imem_wdata (memory write port).
// Modports: master = host/memory side, slave = instr_encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    import isa_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [7:0]        in_operand;
    logic              imem_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    instr_t            imem_wdata;

    modport master (
        output in_valid, in_mnem, in_operand, imem_stall,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_mnem, in_operand, imem_stall,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO of encoded instruction words
// Ports: CLK, RESET_N (async active-low), push/wdata, pop/rdata, full, empty.
// DEPTH must be a power of two and at least 2; push when full and pop when
// empty are ignored.
module instr_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   CLK,
    input  logic   RESET_N,
    input  logic   push,
    input  instr_t wdata,
    input  logic   pop,
    output instr_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - symbolic instruction encoder and instruction-memory loader
// Ports: CLK, RESET_N (async active-low); bus (instr_encoder_if.slave: input
//        stream + imem write port); start/base_addr begin a load; finish ends
//        input; busy, loaded (pulse), err_illegal, err_overflow (sticky),
//        word_count (words written since start).
// Build option: INSTR_ENC_AUTO_DONE_EN adds the TERM state, which appends
//        DONE_WORD after the drain of every load.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    instr_encoder_if.slave    bus,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    output logic              busy,
    output logic              loaded,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic              sat;
    logic              fifo_full;
    logic              fifo_empty;
    instr_t            fifo_head;
    logic              accept;
    logic              push;
    logic              pop;
    logic              term_write;
    logic              commit;

    assign bus.in_ready = (state == ST_STREAM) && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    // Illegal mnemonics complete the handshake but never reach the FIFO.
    assign push         = accept && is_legal(bus.in_mnem);
    assign pop          = ((state == ST_STREAM) || (state == ST_DRAIN))
                          && !fifo_empty && !bus.imem_stall;

`ifdef INSTR_ENC_AUTO_DONE_EN
    assign term_write = (state == ST_TERM) && !bus.imem_stall;
`else
    assign term_write = 1'b0;
`endif

    // Once the last address has been written, slots are still consumed but
    // the strobe is suppressed.
    assign commit         = (pop || term_write) && !sat;
    assign bus.imem_we    = commit;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = !commit ? '0 : (pop ? fifo_head : DONE_WORD);

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (push),
        .wdata   (encode(bus.in_mnem, bus.in_operand)),
        .pop     (pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            addr         <= '0;
            sat          <= 1'b0;
            busy         <= 1'b0;
            loaded       <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            loaded <= 1'b0;

            if (commit) begin
                word_count <= word_count + 1'b1;
                if (addr == '1) begin
                    sat <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
            if ((pop || term_write) && sat) begin
                err_overflow <= 1'b1;
            end
            if (accept && !is_legal(bus.in_mnem)) begin
                err_illegal <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_STREAM;
                        busy         <= 1'b1;
                        addr         <= base_addr;
                        sat          <= 1'b0;
                        word_count   <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (finish) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
`ifdef INSTR_ENC_AUTO_DONE_EN
                        state  <= ST_TERM;
`else
                        state  <= ST_COMPLETE;
                        loaded <= 1'b1;
`endif
                    end
                end
`ifdef INSTR_ENC_AUTO_DONE_EN
                ST_TERM: begin
                    if (!bus.imem_stall) begin
                        state  <= ST_COMPLETE;
                        loaded <= 1'b1;
                    end
                end
`endif
                ST_COMPLETE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

`ifdef INSTR_ENC_AUTO_DONE_EN
    localparam bit AUTO_DONE = 1'b1;
`else
    localparam bit AUTO_DONE = 1'b0;
`endif

    logic       CLK;
    logic       RESET_N;
    logic       start;
    logic [7:0] base_addr;
    logic       finish;
    logic       busy;
    logic       loaded;
    logic       err_illegal;
    logic       err_overflow;
    logic [8:0] word_count;

    bit stall_force;
    bit rand_en;
    bit rand_bit;

    int errors;
    int checks;
    int cyc;
    int loaded_cnt;
    int cap_a[$];
    int cap_d[$];
    int cap_c[$];
    int prog_m[$];
    int prog_o[$];

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .bus          (bus),
        .start        (start),
        .base_addr    (base_addr),
        .finish       (finish),
        .busy         (busy),
        .loaded       (loaded),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    assign bus.imem_stall = stall_force | rand_bit;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        rand_bit = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            rand_bit = rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Write monitor: a strobe seen mid-cycle commits at the next rising edge.
    initial begin
        cyc = 0;
        loaded_cnt = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (bus.imem_we) begin
                cap_a.push_back(int'(bus.imem_addr));
                cap_d.push_back(int'(bus.imem_wdata));
                cap_c.push_back(cyc);
            end
            if (loaded) loaded_cnt++;
        end
    end

    // Reference encoding straight from the instruction format rules.
    function automatic int enc_model(input int m, input int o);
        if (m < 12) return m * 16 + (o % 16);
        if (m == 12) return 256 + o;
        return 240 + (o % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int b);
        start = 1'b1;
        base_addr = b[7:0];
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", bus.in_ready, 1);
    endtask

    task automatic send(input int m, input int o);
        bit ok;
        ok = 1'b0;
        prog_m.push_back(m);
        prog_o.push_back(o);
        bus.in_valid = 1'b1;
        bus.in_mnem = m[3:0];
        bus.in_operand = o[7:0];
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic end_input();
        finish = 1'b1;
        @(posedge CLK);
        #1;
        finish = 1'b0;
    endtask

    task automatic wait_loaded();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (loaded) begin
                ok = 1'b1;
                break;
            end
        end
        chk("loaded_seen", ok, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_writes(input int b, input int mark, input int lmark);
        int exp_a[$];
        int exp_d[$];
        int n;
        bit ill;
        bit ovf;
        n = 0;
        ill = 1'b0;
        ovf = 1'b0;
        foreach (prog_m[i]) begin
            if (prog_m[i] >= 14) begin
                ill = 1'b1;
            end else begin
                if (b + n <= 255) begin
                    exp_a.push_back(b + n);
                    exp_d.push_back(enc_model(prog_m[i], prog_o[i]));
                end else begin
                    ovf = 1'b1;
                end
                n++;
            end
        end
        if (AUTO_DONE) begin
            if (b + n <= 255) begin
                exp_a.push_back(b + n);
                exp_d.push_back(240);
            end else begin
                ovf = 1'b1;
            end
        end
        chk("write_count", cap_a.size() - mark, exp_a.size());
        for (int i = 0; i < exp_a.size() && mark + i < cap_a.size(); i++) begin
            chk("write_addr", cap_a[mark + i], exp_a[i]);
            chk("write_data", cap_d[mark + i], exp_d[i]);
        end
        chk("word_count", word_count, exp_a.size());
        chk("err_illegal", err_illegal, ill);
        chk("err_overflow", err_overflow, ovf);
        chk("loaded_pulses", loaded_cnt - lmark, 1);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_imem_we"}, bus.imem_we, 0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_err_illegal"}, err_illegal, 0);
        chk({tag, "_err_overflow"}, err_overflow, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        int mk;
        int lm;
        errors = 0;
        checks = 0;
        RESET_N = 1'b0;
        start = 1'b0;
        base_addr = '0;
        finish = 1'b0;
        stall_force = 1'b0;
        rand_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mnem = '0;
        bus.in_operand = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_no_write", bus.imem_we, 0);

        // add 3 at 0x10: one-cycle latency to the write strobe
        prog_m.delete(); prog_o.delete();
        mk = cap_a.size(); lm = loaded_cnt;
        do_start(8'h10);
        send(5, 3);
        chk("t1_we", bus.imem_we, 1);
        chk("t1_addr", bus.imem_addr, 8'h10);
        chk("t1_wdata", bus.imem_wdata, 9'h053);
        @(posedge CLK);
        #1;
        chk("t1_word_count", word_count, 1);
        end_input();
        wait_loaded();
        check_writes(8'h10, mk, lm);

        // bne 0xA5 then xor 2: back-to-back writes
        prog_m.delete(); prog_o.delete();
        mk = cap_a.size(); lm = loaded_cnt;
        do_start(8'h10);
        send(12, 8'hA5);
        send(0, 2);
        end_input();
        wait_loaded();
        check_writes(8'h10, mk, lm);
        if (cap_c.size() >= mk + 2) chk("t2_consecutive", cap_c[mk + 1] - cap_c[mk], 1);

        // Stall for several cycles while six words are offered
        prog_m.delete(); prog_o.delete();
        mk = cap_a.size(); lm = loaded_cnt;
        stall_force = 1'b1;
        do_start(8'h20);
        for (int k = 0; k < 4; k++) send($urandom_range(0, 13), $urandom_range(0, 255));
        chk("t3_ready_full", bus.in_ready, 0);
        repeat (4) @(posedge CLK);
        #1;
        chk("t3_ready_still_full", bus.in_ready, 0);
        chk("t3_no_write_in_stall", cap_a.size() - mk, 0);
        stall_force = 1'b0;
        for (int k = 0; k < 2; k++) send($urandom_range(0, 13), $urandom_range(0, 255));
        end_input();
        wait_loaded();
        check_writes(8'h20, mk, lm);

        // Illegal mnemonic is swallowed, sub 1 still written
        prog_m.delete(); prog_o.delete();
        mk = cap_a.size(); lm = loaded_cnt;
        do_start(8'h30);
        send(14, $urandom_range(0, 255));
        send(6, 1);
        end_input();
        wait_loaded();
        check_writes(8'h30, mk, lm);

        // Randomised programs with random stalls, some near the top address
        for (int t = 0; t < 8; t++) begin
            int b;
            int len;
            b = (t % 2 == 1) ? $urandom_range(244, 255) : $urandom_range(0, 255);
            len = $urandom_range(1, 8);
            prog_m.delete(); prog_o.delete();
            mk = cap_a.size(); lm = loaded_cnt;
            rand_en = 1'b1;
            do_start(b);
            for (int k = 0; k < len; k++) send($urandom_range(0, 15), $urandom_range(0, 255));
            end_input();
            wait_loaded();
            rand_en = 1'b0;
            check_writes(b, mk, lm);
        end

        // Address exhaustion at 0xFE, then reset while draining
        prog_m.delete(); prog_o.delete();
        repeat (2) @(posedge CLK);
        #1;
        mk = cap_a.size();
        stall_force = 1'b1;
        do_start(8'hFE);
        for (int k = 0; k < 4; k++) send($urandom_range(0, 13), $urandom_range(0, 255));
        end_input();
        stall_force = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("t6_err_overflow", err_overflow, 1);
        chk("t6_busy_drain", busy, 1);
        chk("t6_write_count", cap_a.size() - mk, 2);
        if (cap_a.size() >= mk + 2) begin
            chk("t6_addr0", cap_a[mk], 8'hFE);
            chk("t6_addr1", cap_a[mk + 1], 8'hFF);
            chk("t6_data0", cap_d[mk], enc_model(prog_m[0], prog_o[0]));
            chk("t6_data1", cap_d[mk + 1], enc_model(prog_m[1], prog_o[1]));
        end
        RESET_N = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        mk = cap_a.size();
        repeat (6) @(negedge CLK);
        chk("post_reset_no_write", cap_a.size() - mk, 0);
        chk("post_reset_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader: accepts symbolic instructions (mnemonic plus operand) over a valid/ready stream and packs each into the 9-bit instruction word format consumed by the control decoder. It buffers the encoded words and writes them sequentially into instruction memory from a programmable base address. It sits between the testbench/host program source and the instruction memory write port, upstream of fetch and decode.

## Interface
- `ADDR_W`, 8: instruction-memory address width.
- `DEPTH`, 4: encoded-word FIFO depth; power of two, at least 2.
- `CLK  in  1`: single clock, rising edge.
- `RESET_N  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse; begins a load at `base_addr`. Honoured only in IDLE.
- `base_addr  in  ADDR_W`: first write address, sampled when `start` is honoured.
- `finish  in  1`: one-cycle pulse; ends input. Honoured only in STREAM.
- `in_valid  in  1`: a symbolic instruction is presented.
- `in_ready  out  1`: the encoder accepts the instruction this cycle.
- `in_mnem  in  4`: 0–11 = xor, lw, sw, mov, put, add, sub, sl, sr, inc, dec, and; 12 = bne; 13 = done; 14–15 are illegal.
- `in_operand  in  8`: register/immediate field for ALU and memory ops (bits [3:0] used); branch target for bne (all 8 bits used).
- `imem_stall  in  1`: memory port busy; no write is allowed this cycle.
- `imem_we  out  1`: write strobe.
- `imem_addr  out  ADDR_W`: write address.
- `imem_wdata  out  9`: encoded instruction word.
- `busy  out  1`: state is not IDLE.
- `loaded  out  1`: one-cycle pulse when a load completes.
- `err_illegal  out  1`: sticky; an illegal mnemonic was accepted.
- `err_overflow  out  1`: sticky; a write was dropped because the address space was exhausted.
- `word_count  out  ADDR_W+1`: number of words written since the last `start`.

## Operation
- **Encoding:**
  - Mnemonics 0–11 encode to `{1'b0, mnem[3:0], operand[3:0]}`; opcode field [8:4] equals the mnemonic.
  - bne (12) encodes to `{1'b1, operand[7:0]}`.
  - done (13) encodes to `{5'b01111, operand[3:0]}`.
  - Illegal mnemonics (14–15) are accepted, produce no FIFO entry, and set `err_illegal`.
- **Handshake:** a transfer occurs when `in_valid && in_ready`. `in_ready = (state==STREAM) && !fifo_full`. The source must hold `in_valid` and its data stable until the transfer.
- **Write side:** whenever the FIFO is non-empty, the state is STREAM or DRAIN, and `!imem_stall`, the head entry is driven with `imem_we=1` and popped at that edge.
  - `imem_addr` then increments.
  - `imem_wdata` is 0 whenever `imem_we=0`.
- **Address limit:** after a write at address 2^ADDR_W−1, the pointer is saturated. Every further pop is discarded (`imem_we` stays 0) and sets `err_overflow`; the address never wraps.
- **FSM:**
  - IDLE: on `start`, load `base_addr`, clear `word_count` and both error flags, go to STREAM.
  - STREAM: on `finish`, go to DRAIN. A transfer in the same cycle as `finish` is still accepted.
  - DRAIN: `in_ready=0`. When the FIFO is empty, go to TERM if the auto-done feature is compiled in, else to COMPLETE.
  - TERM: write `DONE_WORD` (0x0F0) when `!imem_stall`, subject to the address limit, then go to COMPLETE.
  - COMPLETE: `loaded=1` for one cycle, go to IDLE.
- `start` outside IDLE and `finish` outside STREAM are ignored.
- **Reset (including mid-operation):** FIFO emptied, state IDLE, address 0, all outputs 0. No write is issued in the cycle after `RESET_N` deasserts.

## Timing
- Reset values: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `busy`, `loaded`, `err_*`, `word_count` are all 0.
- `start` honoured at edge N: `busy` and `in_ready` are 1 from cycle N+1.
- Latency: a word accepted at edge N appears on `imem_we` in cycle N+1, committing at edge N+1, if the FIFO was empty and there is no stall.
- Throughput: 1 word/cycle sustained, with simultaneous push and pop when not full.
- Stall: FIFO fills after DEPTH accepted words; `in_ready` drops the cycle after the FIFO goes full.
- `word_count` increments on the same edge as each committed write.

## Configuration
- `INSTR_ENC_AUTO_DONE_EN` defined: the TERM state exists, and every load ends with a `DONE_WORD` write after the drain.
- Undefined: DRAIN goes directly to COMPLETE. The program must supply its own done (mnemonic 13).

## Structure
- `isa_pkg` holds:
  - the mnemonic enum `mnem_e` (4-bit);
  - opcode constants `OP_XOR`…`OP_AND`, `OP_DONE` = 5'b01111;
  - `DONE_WORD` = 9'h0F0;
  - `instr_t` = `logic [8:0]`;
  - the FSM state enum.
- Sub-module `instr_fifo`: synchronous FIFO parameterised by DEPTH, with width 9, push/pop, full/empty flags, and asynchronous active-low reset.

## Test plan
- Start with `base_addr`=0x10; add, operand 3 → write addr 0x10, data 0x053; `word_count`=1.
- bne with operand 0xA5, then xor with operand 0x2 → writes 0x1A5 at 0x10 and 0x002 at 0x11, on consecutive cycles.
- Auto-done on: two words, then `finish` → third write 0x0F0 at base+2, `loaded` pulse, `word_count`=3.
- `imem_stall` high for 8 cycles while pushing 6 words (DEPTH=4) → `in_ready` low after 4 accepts; all 6 words are later written in order with no loss.
- Mnemonic 14, then sub with operand 1 → only 0x061 is written; `err_illegal`=1.
- `base_addr`=0xFE; push 3 words → writes at 0xFE and 0xFF only; `err_overflow`=1; reset asserted mid-DRAIN → all outputs 0 and no further writes.
